// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and pointer width for the UART TX arbiter
package uart_tx_arbiter_pkg;
  localparam int MAX_REQ = 8;
  localparam int PTR_W = $clog2(MAX_REQ);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr and wrapping
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);
  logic [N-1:0] rot;
  logic [PTR_W:0] sum;
  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = N'({req, req} >> ptr);
    sum = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) sum = {1'b0, ptr} + (PTR_W + 1)'(i);
    idx = PTR_W'(sum >= (PTR_W + 1)'(N) ? sum - (PTR_W + 1)'(N) : sum);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX between NUM_REQ byte sources
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int Width = 8,
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*Width-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]       REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]       REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [NUM_REQ-1:0]       DONE,
  output logic                     ERR,
  input  logic                     TX_BUSY,
  output logic [Width-1:0]         TX_P_DATA,
  output logic                     TX_DATA_VALID,
  output logic                     TX_PAR_EN,
  output logic                     TX_PAR_TYP,
  output logic                     ARB_BUSY
);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
  state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx, nxt_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] data_q, data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, err_q, err_d, pick_valid;
  logic [NUM_REQ-1:0] done_q, done_d;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (REQ),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign nxt_ptr = owner_q == PTR_W'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;

  // Frame sequencing: arbitrate, launch, wait for busy to rise, then to fall
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    data_d = data_q;
    par_en_d = par_en_q;
    par_typ_d = par_typ_q;
    done_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (pick_valid && !TX_BUSY) begin
        data_d = Width'(REQ_DATA >> (pick_idx * Width));
        par_en_d = 1'(REQ_PAR_EN >> pick_idx);
        par_typ_d = 1'(REQ_PAR_TYP >> pick_idx);
        owner_d = pick_idx;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (TX_BUSY) state_d = WAIT_DONE;
      else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
        err_d = 1'b1;
        ptr_d = nxt_ptr;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      WAIT_DONE: if (!TX_BUSY) begin
        done_d = NUM_REQ'(1) << owner_q;
        ptr_d = nxt_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured frame registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      done_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign GNT = state_q == LAUNCH ? NUM_REQ'(1) << owner_q : '0;
  assign TX_DATA_VALID = state_q == LAUNCH;
  assign ARB_BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign ERR = err_q;
  assign TX_P_DATA = data_q;
  assign TX_PAR_EN = par_en_q;
  assign TX_PAR_TYP = par_typ_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus scoreboarded launches and corner-case sequences
module tb_uart_tx_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] REQ = '0, REQ_PAR_EN = '0, REQ_PAR_TYP = '0, GNT, DONE;
  logic [31:0] REQ_DATA = '0;
  logic ERR, TX_BUSY, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, ARB_BUSY;
  logic [7:0] TX_P_DATA;
  logic model_en = 1'b1, man_busy = 1'b0;
  logic [2:0] mcnt;
  int vectors = 0, miscompares = 0, launches = 0;

  typedef struct {
    int win;
    logic [7:0] data;
    logic pe;
    logic pt;
  } exp_t;
  typedef struct {
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] pe;
    logic [3:0] pt;
    int win;
  } vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t vt[6];

  uart_tx_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_PAR_EN(REQ_PAR_EN),
    .REQ_PAR_TYP(REQ_PAR_TYP), .GNT(GNT), .DONE(DONE), .ERR(ERR), .TX_BUSY(TX_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_PAR_EN(TX_PAR_EN),
    .TX_PAR_TYP(TX_PAR_TYP), .ARB_BUSY(ARB_BUSY)
  );

  always #5 CLK = ~CLK;

  // UART_TX stand-in: busy for five cycles after each DATA_VALID
  always @(posedge CLK or posedge RST)
    if (RST) mcnt <= '0;
    else if (TX_DATA_VALID) mcnt <= 3'd5;
    else if (mcnt != 0) mcnt <= mcnt - 1'b1;
  assign TX_BUSY = model_en ? (mcnt != 0) : man_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int w);
    exp_t x;
    x.win = w;
    x.data = REQ_DATA[w*8 +: 8];
    x.pe = REQ_PAR_EN[w];
    x.pt = REQ_PAR_TYP[w];
    sb.push_back(x);
  endtask

  task automatic wait_done(input logic [3:0] exp);
    int n = 0;
    while (DONE == 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("done", DONE, exp);
  endtask

  // Scoreboard check of every launch against the expected grant
  always @(negedge CLK)
    if (!RST && TX_DATA_VALID) begin
      launches++;
      if (sb.size() == 0) chk("unexpected_launch", 1, 0);
      else begin
        e = sb.pop_front();
        chk("gnt", GNT, 4'b0001 << e.win);
        chk("p_data", TX_P_DATA, e.data);
        chk("par_en", TX_PAR_EN, e.pe);
        chk("par_typ", TX_PAR_TYP, e.pt);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    vt[0] = '{4'b0100, 32'h11A52233, 4'b0100, 4'b0100, 2};
    vt[1] = '{4'b1001, 32'h3C000042, 4'b1000, 4'b0001, 3};
    vt[2] = '{4'b1001, 32'h7E0000C3, 4'b0001, 4'b1001, 0};
    vt[3] = '{4'b0011, 32'h00005A96, 4'b0011, 4'b0010, 1};
    vt[4] = '{4'b0011, 32'h0000F00F, 4'b0000, 4'b0011, 0};
    vt[5] = '{4'b1000, 32'h81000000, 4'b0000, 4'b0000, 3};
    @(negedge CLK);
    chk("rst_gnt", GNT, 0);
    chk("rst_dv", TX_DATA_VALID, 0);
    chk("rst_data", TX_P_DATA, 0);
    chk("rst_busy", ARB_BUSY, 0);
    chk("rst_done_err", {DONE, ERR}, 0);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      REQ_DATA = vt[i].data;
      REQ_PAR_EN = vt[i].pe;
      REQ_PAR_TYP = vt[i].pt;
      push_exp(vt[i].win);
      REQ = vt[i].req;
      @(negedge CLK);
      chk("launch_dv", TX_DATA_VALID, 1);
      REQ = '0;
      wait_done(4'b0001 << vt[i].win);
    end
    REQ_DATA = 32'hD4C3B2A1;
    REQ_PAR_EN = 4'b1010;
    REQ_PAR_TYP = 4'b0110;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    base = launches;
    n = 0;
    REQ = 4'b1111;
    while (launches < base + 5 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    REQ = '0;
    chk("rr_count", launches - base, 5);
    n = 0;
    while (ARB_BUSY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("rr_idle", ARB_BUSY, 0);
    model_en = 1'b0;
    REQ_DATA = 32'h6B5A4938;
    REQ_PAR_EN = 4'b0101;
    REQ_PAR_TYP = 4'b0011;
    push_exp(2);
    REQ = 4'b0100;
    @(negedge CLK);
    chk("to_launch", TX_DATA_VALID, 1);
    REQ = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk("to_err", ERR, k == 5);
      chk("to_nodone", DONE, 0);
    end
    chk("to_idle", ARB_BUSY, 0);
    push_exp(3);
    REQ = 4'b1101;
    @(negedge CLK);
    chk("after_to_launch", TX_DATA_VALID, 1);
    man_busy = 1'b1;
    REQ = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_busy", ARB_BUSY, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_gnt_dv", {GNT, TX_DATA_VALID}, 0);
    chk("arst_data", {TX_P_DATA, TX_PAR_EN, TX_PAR_TYP}, 0);
    chk("arst_busy", ARB_BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    man_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("arst_nodone", DONE, 0);
    end
    man_busy = 1'b1;
    push_exp(0);
    REQ = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("held_busy_gnt", GNT, 0);
    end
    man_busy = 1'b0;
    @(negedge CLK);
    chk("held_release_gnt", GNT, 4'b0001);
    man_busy = 1'b1;
    REQ = '0;
    @(negedge CLK);
    @(negedge CLK);
    man_busy = 1'b0;
    chk("done_early", DONE, 0);
    @(negedge CLK);
    chk("done_latency", DONE, 4'b0001);
    @(negedge CLK);
    chk("done_pulse", DONE, 0);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
